// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, TB8, STOP, DONE} tx_state_t;

    localparam logic MODE0      = 1'b0;
    localparam logic MODE_UART  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// SCON/SBUF-side signal bundle of the serial transmitter.
interface serial_tx_if #(parameter int unsigned DATA_W = 8);

    logic              serial_br_i;
    logic              serial_scon7_sm0_i;
    logic              serial_scon1_ti_i;
    logic              serial_serial_tx_i;
    logic              serial_scon3_tb8_i;
    logic [DATA_W-1:0] serial_data_sbuf_i;
    logic              serial_p3en_0_o;
    logic              serial_p3en_1_o;
    logic              serial_scon1_ti_o;
    logic              serial_send_o;
    logic              serial_data_en_o;
    logic              serial_data_tx_o;

    modport master (
        output serial_br_i, serial_scon7_sm0_i, serial_scon1_ti_i,
               serial_serial_tx_i, serial_scon3_tb8_i, serial_data_sbuf_i,
        input  serial_p3en_0_o, serial_p3en_1_o, serial_scon1_ti_o,
               serial_send_o, serial_data_en_o, serial_data_tx_o
    );

    modport slave (
        input  serial_br_i, serial_scon7_sm0_i, serial_scon1_ti_i,
               serial_serial_tx_i, serial_scon3_tb8_i, serial_data_sbuf_i,
        output serial_p3en_0_o, serial_p3en_1_o, serial_scon1_ti_o,
               serial_send_o, serial_data_en_o, serial_data_tx_o
    );

endinterface

// File: rtl/serial_br_edge.sv
// Baud level register plus single-cycle rise/fall pulses.
module serial_br_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic br_i,
    output logic rise_o,
    output logic fall_o
);

    logic br_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_q <= 1'b0;
        end else begin
            br_q <= br_i;
        end
    end

    assign rise_o = br_i & ~br_q;
    assign fall_o = ~br_i & br_q;

endmodule

// File: rtl/serial_tx.sv
// 8051 serial port transmitter: mode 0 shift register or 9-bit UART frame.
// Optional SERIAL_TX_PARITY_EN replaces TB8 with even parity of the byte.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic        serial_clock_i,
    input  logic        serial_reset_i,
    serial_tx_if.slave  sio
);

    localparam int unsigned     CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    tx_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shr_q;
    logic              bit9_q;
    logic              sm0_q;
    logic              send_q;
    logic              done_q;
    logic              tx_q;
    logic              en_q;
    logic              p3en0_q;
    logic              p3en1_q;
    logic              br_rise;
    logic              br_fall;

    serial_br_edge u_br_edge (
        .clk_i  (serial_clock_i),
        .rst_i  (serial_reset_i),
        .br_i   (sio.serial_br_i),
        .rise_o (br_rise),
        .fall_o (br_fall)
    );

    // IDLE with send_q set is the armed wait for the first baud rise.
    always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
        if (serial_reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shr_q   <= '0;
            bit9_q  <= 1'b0;
            sm0_q   <= MODE0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            en_q    <= 1'b1;
            p3en0_q <= 1'b0;
            p3en1_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (sm0_q == MODE0 && state_q == DATA && br_fall) begin
                en_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!send_q) begin
                        if (sio.serial_serial_tx_i) begin
                            shr_q   <= sio.serial_data_sbuf_i;
`ifdef SERIAL_TX_PARITY_EN
                            bit9_q  <= ^sio.serial_data_sbuf_i;
`else
                            bit9_q  <= sio.serial_scon3_tb8_i;
`endif
                            sm0_q   <= sio.serial_scon7_sm0_i;
                            send_q  <= 1'b1;
                            p3en0_q <= (sio.serial_scon7_sm0_i == MODE0);
                            p3en1_q <= 1'b1;
                        end
                    end else if (br_rise) begin
                        cnt_q <= '0;
                        if (sm0_q == MODE_UART) begin
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= shr_q[0];
                            shr_q   <= shr_q >> 1;
                            en_q    <= 1'b0;
                            state_q <= DATA;
                        end
                    end
                end
                START: begin
                    if (br_rise) begin
                        tx_q    <= shr_q[0];
                        shr_q   <= shr_q >> 1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (br_rise) begin
                        if (cnt_q != LAST) begin
                            cnt_q <= cnt_q + 1'b1;
                            tx_q  <= shr_q[0];
                            shr_q <= shr_q >> 1;
                            if (sm0_q == MODE0) begin
                                en_q <= 1'b0;
                            end
                        end else if (sm0_q == MODE_UART) begin
                            tx_q    <= bit9_q;
                            state_q <= TB8;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            send_q  <= 1'b0;
                            tx_q    <= IDLE_LEVEL;
                            en_q    <= 1'b1;
                            p3en0_q <= 1'b0;
                            p3en1_q <= 1'b0;
                        end
                    end
                end
                TB8: begin
                    if (br_rise) begin
                        tx_q    <= IDLE_LEVEL;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (br_rise) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        send_q  <= 1'b0;
                        tx_q    <= IDLE_LEVEL;
                        en_q    <= 1'b1;
                        p3en0_q <= 1'b0;
                        p3en1_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sio.serial_p3en_0_o   = p3en0_q;
    assign sio.serial_p3en_1_o   = p3en1_q;
    assign sio.serial_scon1_ti_o = sio.serial_scon1_ti_i | done_q;
    assign sio.serial_send_o     = send_q;
    assign sio.serial_data_en_o  = en_q;
    assign sio.serial_data_tx_o  = tx_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: mode 0, UART, busy strobe, mid-frame reset, ninth bit.
module tb_serial_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    serial_tx_if #(.DATA_W(8)) sio();

    serial_tx #(.DATA_W(8)) dut (
        .serial_clock_i (clk),
        .serial_reset_i (rst),
        .sio            (sio)
    );

    always #5 clk = ~clk;

`ifdef SERIAL_TX_PARITY_EN
    localparam logic [10:0] EXP_A5 = 11'b10101001010;
    localparam logic [10:0] EXP_07 = 11'b11000001110;
`else
    localparam logic [10:0] EXP_A5 = 11'b11101001010;
    localparam logic [10:0] EXP_07 = 11'b10000001110;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected line bits are listed rightmost-first: exp[0] is the first bit driven.
    task automatic frame(input string tag, input logic [7:0] sbuf, input logic sm0,
                         input logic tb8, input logic [10:0] exp, input int unsigned nbits,
                         input int busy_at, input logic ti_in, input logic strobe_in_done);
        sio.serial_data_sbuf_i = sbuf;
        sio.serial_scon7_sm0_i = sm0;
        sio.serial_scon3_tb8_i = tb8;
        sio.serial_scon1_ti_i  = ti_in;
        sio.serial_serial_tx_i = 1'b1;
        tick();
        sio.serial_serial_tx_i = 1'b0;
        chk({tag, " send_start"}, sio.serial_send_o, 1'b1);
        chk({tag, " p3en0_busy"}, sio.serial_p3en_0_o, sm0 ? 1'b0 : 1'b1);
        chk({tag, " p3en1_busy"}, sio.serial_p3en_1_o, 1'b1);
        chk({tag, " tx_armed"}, sio.serial_data_tx_o, 1'b1);
        for (int i = 0; i < int'(nbits); i++) begin
            sio.serial_br_i = 1'b1;
            tick();
            chk($sformatf("%s bit%0d", tag, i), sio.serial_data_tx_o, exp[i]);
            chk($sformatf("%s en_rise%0d", tag, i), sio.serial_data_en_o, sm0 ? 1'b1 : 1'b0);
            chk($sformatf("%s ti_mid%0d", tag, i), sio.serial_scon1_ti_o, ti_in);
            if (i == busy_at) begin
                sio.serial_data_sbuf_i = 8'hFF;
                sio.serial_scon3_tb8_i = 1'b1;
                sio.serial_serial_tx_i = 1'b1;
                tick();
                sio.serial_serial_tx_i = 1'b0;
                chk({tag, " send_busy"}, sio.serial_send_o, 1'b1);
                repeat (2) tick();
            end else begin
                repeat (3) tick();
            end
            sio.serial_br_i = 1'b0;
            tick();
            chk($sformatf("%s en_fall%0d", tag, i), sio.serial_data_en_o, 1'b1);
            repeat (3) tick();
        end
        sio.serial_br_i = 1'b1;
        tick();
        chk({tag, " ti_done"}, sio.serial_scon1_ti_o, 1'b1);
        chk({tag, " send_done"}, sio.serial_send_o, 1'b0);
        chk({tag, " tx_done"}, sio.serial_data_tx_o, 1'b1);
        chk({tag, " en_done"}, sio.serial_data_en_o, 1'b1);
        chk({tag, " p3en_done"}, {sio.serial_p3en_1_o, sio.serial_p3en_0_o}, 2'b00);
        sio.serial_br_i = 1'b0;
        if (strobe_in_done) sio.serial_serial_tx_i = 1'b1;
        tick();
        chk({tag, " send_after"}, sio.serial_send_o, 1'b0);
        chk({tag, " ti_after"}, sio.serial_scon1_ti_o, ti_in);
    endtask

    initial begin
        sio.serial_br_i        = 1'b0;
        sio.serial_scon7_sm0_i = 1'b0;
        sio.serial_scon1_ti_i  = 1'b0;
        sio.serial_serial_tx_i = 1'b0;
        sio.serial_scon3_tb8_i = 1'b0;
        sio.serial_data_sbuf_i = 8'h00;
        repeat (3) tick();
        chk("rst tx", sio.serial_data_tx_o, 1'b1);
        chk("rst en", sio.serial_data_en_o, 1'b1);
        chk("rst send", sio.serial_send_o, 1'b0);
        chk("rst p3en", {sio.serial_p3en_1_o, sio.serial_p3en_0_o}, 2'b00);
        chk("rst ti0", sio.serial_scon1_ti_o, 1'b0);
        sio.serial_scon1_ti_i = 1'b1;
        #1;
        chk("rst ti1", sio.serial_scon1_ti_o, 1'b1);
        sio.serial_scon1_ti_i = 1'b0;
        rst = 1'b0;
        tick();

        frame("m0_33", 8'h33, 1'b0, 1'b0, 11'h033, 8, -1, 1'b0, 1'b1);
        frame("m0_B6", 8'hB6, 1'b0, 1'b0, 11'h0B6, 8, -1, 1'b0, 1'b0);
        frame("u_A5", 8'hA5, 1'b1, 1'b1, EXP_A5, 11, -1, 1'b0, 1'b0);
        frame("u_busy", 8'h5A, 1'b1, 1'b0, 11'b10010110100, 11, 3, 1'b0, 1'b0);

        // Mid-frame reset on data bit 4 of 0x2C (that bit is 0).
        sio.serial_data_sbuf_i = 8'h2C;
        sio.serial_scon7_sm0_i = 1'b1;
        sio.serial_serial_tx_i = 1'b1;
        tick();
        sio.serial_serial_tx_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sio.serial_br_i = 1'b1;
            repeat (4) tick();
            sio.serial_br_i = 1'b0;
            repeat (4) tick();
        end
        sio.serial_br_i = 1'b1;
        tick();
        chk("rstmid bit4", sio.serial_data_tx_o, 1'b0);
        rst = 1'b1;
        #2;
        chk("rstmid tx", sio.serial_data_tx_o, 1'b1);
        chk("rstmid send", sio.serial_send_o, 1'b0);
        chk("rstmid p3en", {sio.serial_p3en_1_o, sio.serial_p3en_0_o}, 2'b00);
        chk("rstmid ti", sio.serial_scon1_ti_o, 1'b0);
        tick();
        rst = 1'b0;
        sio.serial_br_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sio.serial_br_i = 1'b1;
            repeat (4) tick();
            chk($sformatf("rstmid ti_quiet%0d", i), sio.serial_scon1_ti_o, 1'b0);
            sio.serial_br_i = 1'b0;
            repeat (4) tick();
            chk($sformatf("rstmid send_quiet%0d", i), sio.serial_send_o, 1'b0);
        end

        frame("u_07", 8'h07, 1'b1, 1'b0, EXP_07, 11, -1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
